cc_random3_source: RTL
======================

// Module: cc_random3_source
// PURPOSE
//  Producer side of the obstacle-row path: generates the RANDOM pattern, the NADA pattern and the select code that the MUX8 obstacle selector consumes.
//  An 8-bit LFSR produces random rows. GAP_ROWS blank (NADA) rows follow every random row so a path always stays passable.
//  Rows are paced by a cycle counter and handed downstream over a valid/ready handshake.
// PARAMETERS
//  RANDGEN_SELECTWIDTH  2      select code width; must match MUX8_SELECTWIDTH
//  RANDGEN_NADAWIDTH    8      NADA bus width; must match MUX8_NADAWIDTH
//  RANDGEN_RANDOMWIDTH  8      RANDOM bus width; fixed at 8 (LFSR taps are hard-coded)
//  RANDGEN_PERIOD       4      pacing cycles before each row, 1..65535
//  RANDGEN_GAP_ROWS     1      NADA rows emitted after each random row, 0..15
//  RANDGEN_SEED         8'hA5  LFSR reset value; 0 is replaced by 8'h01
// PORTS
//  CC_RANDGEN_CLOCK_50       in   1      system clock, rising edge
//  CC_RANDGEN_RESET_InLow    in   1      asynchronous reset, active low
//  CC_RANDGEN_enable_In      in   1      1 = generate rows
//  CC_RANDGEN_ready_In       in   1      consumer accepts the current row
//  CC_RANDGEN_valid_Out      out  1      row outputs valid
//  CC_RANDGEN_select_OutBUS  out  SEL    0 = RANDOM row, 1 = NADA row
//  CC_RANDGEN_RANDOM_OutBUS  out  RAND   random pattern; 0 during a NADA row
//  CC_RANDGEN_NADA_OutBUS    out  NADA   blank pattern, constant all-zero
// BEHAVIOUR
//  Reset (async, low): state IDLE. valid=0, select=0, RANDOM=0, NADA=0. lfsr=SEED, pace_cnt=0, gap_cnt=0.
//  LFSR: fb = l[7]^l[5]^l[4]^l[3]; next = {l[6:0],fb}.
//    A random row emits the current lfsr value, and lfsr advances once at that emit edge.
//    If lfsr is ever all-zero, the next value is 8'h01.
//  FSM states: IDLE, PACE, EMIT_RAND, EMIT_NADA.
//   IDLE: enable=1 -> PACE, pace_cnt=PERIOD-1.
//   PACE: enable=0 -> IDLE, pace_cnt=0.
//     Otherwise, pace_cnt!=0 -> decrement.
//     pace_cnt==0 with gap_cnt==0 -> EMIT_RAND: RANDOM=lfsr, select=0, valid=1.
//     pace_cnt==0 with gap_cnt!=0 -> EMIT_NADA: RANDOM=0, select=1, valid=1.
//   EMIT_*: while ready=0, all outputs and lfsr hold stable.
//     valid is never withdrawn, even if enable drops.
//     On valid&ready: valid=0 on the next edge. Then:
//       EMIT_RAND: gap_cnt=GAP_ROWS.
//       EMIT_NADA: gap_cnt=gap_cnt-1.
//       enable=1 -> PACE with pace_cnt=PERIOD-1; enable=0 -> IDLE.
//     RANDOM and select keep their last values after accept.
//  Latency: valid rises PERIOD cycles after the edge where enable is sampled high in IDLE.
//  Throughput: with ready tied to 1, one row every PERIOD+1 cycles.
//  GAP_ROWS=0: every row is a random row.
//  Reset mid-row: the row is dropped, outputs return to reset values immediately, and the LFSR restarts from SEED.
// CONFIGURATION
//  RANDGEN_SEED_LOAD_EN defined:
//    Adds ports CC_RANDGEN_seedLoad_In (in 1) and CC_RANDGEN_seed_InBUS (in 8).
//    seedLoad=1 in any state: lfsr=seed on the next edge (0 -> 8'h01). This overrides a same-cycle advance.
//    Row outputs, valid and the FSM are unaffected.
//  Not defined: these ports do not exist, and lfsr is loaded only by reset.
// TESTING
//  1 Reset, enable=1, ready=1, defaults -> valid at cycle 4 with select=0, RANDOM=8'hA5.
//    Next row 5 cycles later: select=1, RANDOM=0.
//    Next random row: RANDOM=8'h4A, then 8'h95.
//  2 Hold ready=0 for 10 cycles while valid -> outputs and valid stable.
//    Raise ready -> accepted once, no value skipped (next random is still 8'h4A).
//  3 Drop enable mid-PACE -> IDLE, no valid.
//    Drop enable while valid pending -> row held until accepted, then IDLE.
//  4 RANDGEN_GAP_ROWS=0, RANDGEN_PERIOD=1, ready=1 -> a random row every 2 cycles: A5, 4A, 95.
//  5 Assert reset for 1 cycle while valid=1 -> valid=0 asynchronously.
//    After release and enable: first row RANDOM=8'hA5 again.
//  6 RANDGEN_SEED_LOAD_EN: load seed=0 -> next random row 8'h01.
//    Load 8'hA5 in the same cycle as an emit -> next random row is 8'hA5.

Source files
------------

// File: rtl/cc_random3_source.sv
// Obstacle-row producer: LFSR random rows interleaved with blank (NADA) gap rows, paced and valid/ready handshaked.
// Optional RANDGEN_SEED_LOAD_EN adds a runtime seed-load port pair.
module cc_random3_source #(
   parameter int          RANDGEN_SELECTWIDTH = 2,
   parameter int          RANDGEN_NADAWIDTH   = 8,
   parameter int          RANDGEN_RANDOMWIDTH = 8,
   parameter int          RANDGEN_PERIOD      = 4,
   parameter int          RANDGEN_GAP_ROWS    = 1,
   parameter logic [7:0]  RANDGEN_SEED        = 8'hA5
) (
   input  logic                           CC_RANDGEN_CLOCK_50,
   input  logic                           CC_RANDGEN_RESET_InLow,
   input  logic                           CC_RANDGEN_enable_In,
   input  logic                           CC_RANDGEN_ready_In,
`ifdef RANDGEN_SEED_LOAD_EN
   input  logic                           CC_RANDGEN_seedLoad_In,
   input  logic [7:0]                     CC_RANDGEN_seed_InBUS,
`endif
   output logic                           CC_RANDGEN_valid_Out,
   output logic [RANDGEN_SELECTWIDTH-1:0] CC_RANDGEN_select_OutBUS,
   output logic [RANDGEN_RANDOMWIDTH-1:0] CC_RANDGEN_RANDOM_OutBUS,
   output logic [RANDGEN_NADAWIDTH-1:0]   CC_RANDGEN_NADA_OutBUS
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_PACE      = 2'd1;
   localparam logic [1:0] ST_EMIT_RAND = 2'd2;
   localparam logic [1:0] ST_EMIT_NADA = 2'd3;

   localparam logic [15:0] PACE_RELOAD = 16'(RANDGEN_PERIOD - 1);
   localparam logic [3:0]  GAP_RELOAD  = 4'(RANDGEN_GAP_ROWS);
   localparam logic [7:0]  SEED_EFF    = (RANDGEN_SEED == 8'h00) ? 8'h01 : RANDGEN_SEED;

   logic [1:0]                     state_q, state_d;
   logic [15:0]                    pace_q, pace_d;
   logic [3:0]                     gap_q, gap_d;
   logic [7:0]                     lfsr_q, lfsr_d;
   logic                           valid_q, valid_d;
   logic [RANDGEN_SELECTWIDTH-1:0] sel_q, sel_d;
   logic [RANDGEN_RANDOMWIDTH-1:0] rand_q, rand_d;
   logic [7:0]                     lfsr_adv;

   // An all-zero register would lock up, so it always steps to 8'h01.
   always_comb begin
      if (lfsr_q == 8'h00) begin
         lfsr_adv = 8'h01;
      end else begin
         lfsr_adv = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   always_comb begin
      state_d = state_q;
      pace_d  = pace_q;
      gap_d   = gap_q;
      lfsr_d  = lfsr_q;
      valid_d = valid_q;
      sel_d   = sel_q;
      rand_d  = rand_q;
      case (state_q)
         ST_IDLE: begin
            if (CC_RANDGEN_enable_In) begin
               state_d = ST_PACE;
               pace_d  = PACE_RELOAD;
            end
         end
         ST_PACE: begin
            if (!CC_RANDGEN_enable_In) begin
               state_d = ST_IDLE;
               pace_d  = '0;
            end else if (pace_q != 16'd0) begin
               pace_d = pace_q - 16'd1;
            end else if (gap_q == 4'd0) begin
               state_d = ST_EMIT_RAND;
               rand_d  = lfsr_q;
               sel_d   = '0;
               valid_d = 1'b1;
               lfsr_d  = lfsr_adv;
            end else begin
               state_d = ST_EMIT_NADA;
               rand_d  = '0;
               sel_d   = RANDGEN_SELECTWIDTH'(1);
               valid_d = 1'b1;
            end
         end
         ST_EMIT_RAND, ST_EMIT_NADA: begin
            // Row stays offered regardless of enable until the consumer takes it.
            if (CC_RANDGEN_ready_In) begin
               valid_d = 1'b0;
               gap_d   = (state_q == ST_EMIT_RAND) ? GAP_RELOAD : gap_q - 4'd1;
               if (CC_RANDGEN_enable_In) begin
                  state_d = ST_PACE;
                  pace_d  = PACE_RELOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef RANDGEN_SEED_LOAD_EN
      if (CC_RANDGEN_seedLoad_In) begin
         lfsr_d = (CC_RANDGEN_seed_InBUS == 8'h00) ? 8'h01 : CC_RANDGEN_seed_InBUS;
      end
`endif
   end

   always_ff @(posedge CC_RANDGEN_CLOCK_50 or negedge CC_RANDGEN_RESET_InLow) begin
      if (!CC_RANDGEN_RESET_InLow) begin
         state_q <= ST_IDLE;
         pace_q  <= '0;
         gap_q   <= '0;
         lfsr_q  <= SEED_EFF;
         valid_q <= 1'b0;
         sel_q   <= '0;
         rand_q  <= '0;
      end else begin
         state_q <= state_d;
         pace_q  <= pace_d;
         gap_q   <= gap_d;
         lfsr_q  <= lfsr_d;
         valid_q <= valid_d;
         sel_q   <= sel_d;
         rand_q  <= rand_d;
      end
   end

   assign CC_RANDGEN_valid_Out     = valid_q;
   assign CC_RANDGEN_select_OutBUS = sel_q;
   assign CC_RANDGEN_RANDOM_OutBUS = rand_q;
   assign CC_RANDGEN_NADA_OutBUS   = '0;

endmodule
